// File: rtl/cache_controller.sv
// Two-line direct-mapped snooping cache controller (MSI) with a shared message bus.
// One outstanding CPU request; snoop write-backs preempt the controller's own bus messages.
module cache_controller #(
   parameter logic [1:0] ReadMiss   = 2'b00,
   parameter logic [1:0] WriteMiss  = 2'b01,
   parameter logic [1:0] Invalidate = 2'b10,
   parameter logic [1:0] WriteBack  = 2'b11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cpu_rd,
   input  logic       cpu_wr,
   input  logic [1:0] cpu_addr,
   input  logic [3:0] cpu_wdata,
   output logic [3:0] cpu_rdata,
   output logic       cpu_ready,
   output logic [7:0] bus_out,
   output logic       bus_out_valid,
   input  logic [7:0] bus_in,
   input  logic       bus_in_valid,
   input  logic [3:0] mem_q
);

   typedef enum logic [1:0] {LINE_I, LINE_S, LINE_M} line_state_e;
   typedef enum logic [2:0] {IDLE, WB, MISS, WAIT, FILL, UPG} state_e;

   state_e      state_q, state_d;
   line_state_e line_st_q   [2];
   line_state_e line_st_d   [2];
   logic [1:0]  line_tag_q  [2];
   logic [1:0]  line_tag_d  [2];
   logic [3:0]  line_data_q [2];
   logic [3:0]  line_data_d [2];

   logic [1:0] addr_q, addr_d;
   logic [3:0] wdata_q, wdata_d;
   logic       is_wr_q, is_wr_d;
   logic [3:0] mem_data_q, mem_data_d;
   logic       ready_q, ready_d;
   logic [3:0] rdata_q, rdata_d;
   logic       pend_q, pend_d;
   logic [1:0] pend_tag_q, pend_tag_d;
   logic [3:0] pend_data_q, pend_data_d;

   logic [1:0] snp_code;
   logic [1:0] snp_tag;
   logic       snp_idx;
   logic       snp_skip;
   logic       snp_match;
   logic       snp_share;
   logic       snp_kill;
   logic       req_idx;
   logic       req_hit;
   logic       act_idx;
   logic       upg_ok;
   logic [3:0] fill_data;

   assign snp_code = bus_in[7:6];
   assign snp_tag  = bus_in[5:4];
   assign snp_idx  = snp_tag[0];

   // The block being fetched is not ours yet, and the victim in WB is already leaving.
   assign snp_skip = ((state_q == MISS || state_q == WAIT || state_q == FILL) && snp_tag == addr_q)
                   || (state_q == WB && snp_idx == addr_q[0]);

   assign snp_match = bus_in_valid && !snp_skip
                    && line_st_q[snp_idx] != LINE_I && line_tag_q[snp_idx] == snp_tag;
   assign snp_share = snp_match && snp_code == ReadMiss;
   assign snp_kill  = snp_match && !snp_share
                    && (snp_code == WriteMiss || snp_code == Invalidate);

   assign req_idx = cpu_addr[0];
   assign req_hit = line_st_q[req_idx] != LINE_I && line_tag_q[req_idx] == cpu_addr;

   assign act_idx   = addr_q[0];
   assign upg_ok    = line_st_q[act_idx] == LINE_S && line_tag_q[act_idx] == addr_q
                    && !(snp_kill && snp_idx == act_idx);
   assign fill_data = is_wr_q ? wdata_q : mem_data_q;

   assign cpu_ready = ready_q || (state_q == FILL && !pend_q);
   assign cpu_rdata = (state_q == FILL) ? fill_data : rdata_q;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d       = state_q;
      line_st_d     = line_st_q;
      line_tag_d    = line_tag_q;
      line_data_d   = line_data_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      is_wr_d       = is_wr_q;
      mem_data_d    = mem_data_q;
      ready_d       = 1'b0;
      rdata_d       = rdata_q;
      pend_d        = 1'b0;
      pend_tag_d    = pend_tag_q;
      pend_data_d   = pend_data_q;
      bus_out       = 8'h00;
      bus_out_valid = 1'b0;

      if (pend_q) begin
         bus_out       = {WriteBack, pend_tag_q, pend_data_q};
         bus_out_valid = 1'b1;
      end

      if (snp_share && line_st_q[snp_idx] == LINE_M) begin
         line_st_d[snp_idx] = LINE_S;
         pend_d             = 1'b1;
         pend_tag_d         = snp_tag;
         pend_data_d        = line_data_q[snp_idx];
      end else if (snp_kill) begin
         line_st_d[snp_idx] = LINE_I;
         if (line_st_q[snp_idx] == LINE_M) begin
            pend_d      = 1'b1;
            pend_tag_d  = snp_tag;
            pend_data_d = line_data_q[snp_idx];
         end
      end

      // A pending snoop write-back owns the bus, so message-issuing states hold.
      case (state_q)
         IDLE: begin
            if (!pend_q && !ready_q && !snp_match && (cpu_rd || cpu_wr)) begin
               addr_d  = cpu_addr;
               wdata_d = cpu_wdata;
               is_wr_d = cpu_wr;
               if (req_hit && !cpu_wr) begin
                  ready_d = 1'b1;
                  rdata_d = line_data_q[req_idx];
               end else if (req_hit && line_st_q[req_idx] == LINE_M) begin
                  line_data_d[req_idx] = cpu_wdata;
                  ready_d              = 1'b1;
                  rdata_d              = cpu_wdata;
               end else if (req_hit) begin
                  state_d = UPG;
               end else if (line_st_q[req_idx] == LINE_M) begin
                  state_d = WB;
               end else begin
                  state_d = MISS;
               end
            end
         end
         WB: begin
            if (!pend_q) begin
               bus_out            = {WriteBack, line_tag_q[act_idx], line_data_q[act_idx]};
               bus_out_valid      = 1'b1;
               line_st_d[act_idx] = LINE_I;
               state_d            = MISS;
            end
         end
         MISS: begin
            if (!pend_q) begin
               bus_out       = {(is_wr_q ? WriteMiss : ReadMiss), addr_q, 4'h0};
               bus_out_valid = 1'b1;
               state_d       = WAIT;
            end
         end
         WAIT: begin
            mem_data_d = mem_q;
            state_d    = FILL;
         end
         FILL: begin
            if (!pend_q) begin
               line_st_d[act_idx]   = is_wr_q ? LINE_M : LINE_S;
               line_tag_d[act_idx]  = addr_q;
               line_data_d[act_idx] = fill_data;
               state_d              = IDLE;
            end
         end
         UPG: begin
            if (!pend_q) begin
               if (upg_ok) begin
                  bus_out              = {Invalidate, addr_q, 4'h0};
                  bus_out_valid        = 1'b1;
                  line_st_d[act_idx]   = LINE_M;
                  line_data_d[act_idx] = wdata_q;
                  ready_d              = 1'b1;
                  rdata_d              = wdata_q;
                  state_d              = IDLE;
               end else begin
                  // Our copy was invalidated under us: fetch it as a write miss instead.
                  state_d = MISS;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         line_st_q <= '{default: LINE_I};
         ready_q   <= 1'b0;
         rdata_q   <= 4'h0;
         pend_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         line_st_q <= line_st_d;
         ready_q   <= ready_d;
         rdata_q   <= rdata_d;
         pend_q    <= pend_d;
      end
   end

   // NOTE: tag/data storage is left unreset; a line's state alone decides whether it is valid.
   always_ff @(posedge clk) begin
      line_tag_q  <= line_tag_d;
      line_data_q <= line_data_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      is_wr_q     <= is_wr_d;
      mem_data_q  <= mem_data_d;
      pend_tag_q  <= pend_tag_d;
      pend_data_q <= pend_data_d;
   end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: hand-computed bus messages, latencies and read data.
// Inputs change on the falling edge (or just after a rising edge); outputs are sampled on the falling edge.
module tb_cache_controller;

   logic       clk;
   logic       rst;
   logic       cpu_rd;
   logic       cpu_wr;
   logic [1:0] cpu_addr;
   logic [3:0] cpu_wdata;
   logic [3:0] cpu_rdata;
   logic       cpu_ready;
   logic [7:0] bus_out;
   logic       bus_out_valid;
   logic [7:0] bus_in;
   logic       bus_in_valid;
   logic [3:0] mem_q;

   int checks = 0;
   int errors = 0;

   cache_controller dut (
      .clk           (clk),
      .rst           (rst),
      .cpu_rd        (cpu_rd),
      .cpu_wr        (cpu_wr),
      .cpu_addr      (cpu_addr),
      .cpu_wdata     (cpu_wdata),
      .cpu_rdata     (cpu_rdata),
      .cpu_ready     (cpu_ready),
      .bus_out       (bus_out),
      .bus_out_valid (bus_out_valid),
      .bus_in        (bus_in),
      .bus_in_valid  (bus_in_valid),
      .mem_q         (mem_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic bus(input string tag, input logic valid, input logic [7:0] msg);
      check({tag, "_valid"}, bus_out_valid, valid);
      check({tag, "_msg"}, bus_out, msg);
   endtask

   task automatic done(input string tag, input logic [3:0] data);
      check({tag, "_ready"}, cpu_ready, 1'b1);
      check({tag, "_rdata"}, cpu_rdata, data);
   endtask

   task automatic req(input logic rd, input logic wr, input logic [1:0] addr, input logic [3:0] wd);
      cpu_rd    = rd;
      cpu_wr    = wr;
      cpu_addr  = addr;
      cpu_wdata = wd;
   endtask

   task automatic drop();
      cpu_rd = 1'b0;
      cpu_wr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 2'd0; cpu_wdata = 4'h0;
      bus_in = 8'h00; bus_in_valid = 1'b0; mem_q = 4'h3;
      cyc(); cyc();
      check("rst_ready", cpu_ready, 1'b0);
      check("rst_rdata", cpu_rdata, 4'h0);
      bus("rst_bus", 1'b0, 8'h00);
      rst = 1'b0;
      cyc();

      // Cold read of addr 2; mem_q is only correct during the WAIT cycle.
      req(1'b1, 1'b0, 2'd2, 4'h0);
      cyc(); bus("cold_rm", 1'b1, 8'h20); check("cold_early_ready", cpu_ready, 1'b0);
      cyc(); bus("cold_wait", 1'b0, 8'h00); mem_q = 4'hA;
      cyc(); done("cold_fill", 4'hA); mem_q = 4'h3; drop();
      cyc(); check("cold_single_pulse", cpu_ready, 1'b0);
      req(1'b1, 1'b0, 2'd2, 4'h0);
      cyc(); done("rd_hit", 4'hA); check("rd_hit_nobus", bus_out_valid, 1'b0); drop();
      cyc();

      // Write miss to addr 1; address/data changes after acceptance must be ignored.
      req(1'b0, 1'b1, 2'd1, 4'h5);
      cyc(); bus("wr_miss", 1'b1, 8'h50); cpu_addr = 2'd0; cpu_wdata = 4'hF;
      cyc();
      cyc(); done("wr_fill", 4'h5); drop();
      cyc();

      // Read addr 3 evicts the dirty line at index 1.
      req(1'b1, 1'b0, 2'd3, 4'h0);
      cyc(); bus("dirty_wb", 1'b1, 8'hD5);
      cyc(); bus("dirty_rm", 1'b1, 8'h30);
      cyc(); mem_q = 4'h9;
      cyc(); done("dirty_fill", 4'h9); mem_q = 4'h3; drop();
      cyc();

      // Clean miss on addr 0, then a write hit on the S line upgrades it.
      req(1'b1, 1'b0, 2'd0, 4'h0);
      cyc(); bus("s0_rm", 1'b1, 8'h00);
      cyc(); mem_q = 4'h6;
      cyc(); done("s0_fill", 4'h6); mem_q = 4'h3; drop();
      cyc();
      req(1'b0, 1'b1, 2'd0, 4'h7);
      cyc(); bus("upg_inv", 1'b1, 8'h80); check("upg_early_ready", cpu_ready, 1'b0);
      cyc(); done("upg_done", 4'h7); check("upg_nobus", bus_out_valid, 1'b0); drop();
      cyc();
      req(1'b1, 1'b0, 2'd0, 4'h0);
      cyc(); done("m0_hit", 4'h7); drop();
      cyc();

      // Dirty write miss to addr 2, then a snooped ReadMiss forces a write-back.
      req(1'b0, 1'b1, 2'd2, 4'hC);
      cyc(); bus("wm2_wb", 1'b1, 8'hC7);
      cyc(); bus("wm2_wm", 1'b1, 8'h60);
      cyc();
      cyc(); done("wm2_fill", 4'hC); drop();
      cyc();
      bus_in = 8'h20; bus_in_valid = 1'b1;
      cyc(); bus("snp_wb", 1'b1, 8'hEC); bus_in = 8'h00; bus_in_valid = 1'b0;
      cyc(); bus("snp_once", 1'b0, 8'h00);
      req(1'b0, 1'b1, 2'd2, 4'h1);
      cyc(); bus("snp_s_upg", 1'b1, 8'hA0);
      cyc(); done("snp_s_done", 4'h1); drop();
      cyc();

      // Re-load addr 0 as S, then race an upgrade against a snooped Invalidate.
      req(1'b1, 1'b0, 2'd0, 4'h0);
      cyc(); bus("r0_wb", 1'b1, 8'hE1);
      cyc(); bus("r0_rm", 1'b1, 8'h00);
      cyc(); mem_q = 4'h4;
      cyc(); done("r0_fill", 4'h4); mem_q = 4'h3; drop();
      cyc();
      req(1'b0, 1'b1, 2'd0, 4'h8);
      @(posedge clk); #1 bus_in = 8'h80; bus_in_valid = 1'b1;
      @(negedge clk); bus("race_no_inv", 1'b0, 8'h00);
      @(posedge clk); #1 bus_in = 8'h00; bus_in_valid = 1'b0;
      @(negedge clk); bus("race_wm", 1'b1, 8'h40);
      cyc();
      cyc(); done("race_fill", 4'h8); drop();
      cyc();

      // Reset during WAIT aborts the miss and invalidates every line.
      req(1'b1, 1'b0, 2'd1, 4'h0);
      cyc(); bus("abort_rm", 1'b1, 8'h10);
      cyc(); rst = 1'b1; drop();
      cyc(); check("abort_ready", cpu_ready, 1'b0); bus("abort_bus", 1'b0, 8'h00); rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check($sformatf("abort_quiet_ready%0d", i), cpu_ready, 1'b0);
         check($sformatf("abort_quiet_bus%0d", i), bus_out_valid, 1'b0);
      end
      req(1'b1, 1'b0, 2'd0, 4'h0);
      cyc(); bus("post_rst_rm", 1'b1, 8'h00); check("post_rst_nohit", cpu_ready, 1'b0);
      cyc(); mem_q = 4'h2;
      cyc(); done("post_rst_fill", 4'h2); mem_q = 4'h3; drop();
      cyc();

      // Read and write together: the write wins and upgrades the S line.
      req(1'b1, 1'b1, 2'd0, 4'hB);
      cyc(); bus("both_inv", 1'b1, 8'h80);
      cyc(); done("both_done", 4'hB); drop();
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
